cal_dow_engine: RTL and testbench



---
 rtl/cal_pkg.sv | 55 +++++
 rtl/cal_date_check.sv | 36 +++
 rtl/cal_dow_engine.sv | 171 +++++++++++++++++
 tb/tb_cal_dow_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// ============================================================
// cal_pkg : shared calendar constants, tables and helpers
// Rev 1.0
// ============================================================
`default_nettype none

package cal_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DOW   = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] DOW_SUN = 3'd0;
    localparam logic [2:0] DOW_SAT = 3'd6;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_YEAR = 2'd1;
    localparam logic [1:0] ERR_DATE = 2'd2;
    localparam logic [1:0] ERR_OVF  = 2'd3;

    // Per-month offsets for the year-shifted day-of-week formula
    localparam logic [2:0] T_OFFSET [0:11] = '{
        3'd0, 3'd3, 3'd2, 3'd5, 3'd0, 3'd3, 3'd5, 3'd1, 3'd4, 3'd6, 3'd2, 3'd4
    };

    localparam logic [4:0] DIM_TABLE [0:11] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    function automatic logic is_leap(input logic [31:0] year);
        return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) ||
               (year % 32'd400 == 32'd0);
    endfunction

    // Returns 0 for an illegal month so any day compares as invalid
    function automatic logic [4:0] days_in_month(input logic [31:0] year,
                                                 input logic [3:0]  month);
        logic [4:0] d;
        d = 5'd0;
        if (month >= 4'd1 && month <= 4'd12) begin
            d = DIM_TABLE[month - 4'd1];
            if (month == 4'd2 && is_leap(year))
                d = 5'd29;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cal_date_check.sv
// ============================================================
// cal_date_check : combinational year-range and month/day validation
// Rev 1.0
// ============================================================
`default_nettype none

module cal_date_check
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 16,
    parameter int YEAR_MIN = 1755,
    parameter int YEAR_MAX = 2033
) (
    input  logic [YEAR_W-1:0] year,
    input  logic [3:0]        month,
    input  logic [4:0]        day,
    output logic [1:0]        err,
    output logic [4:0]        dim
);

    localparam logic [YEAR_W-1:0] c_year_min = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);

    assign dim = days_in_month(32'(year), month);

    always_comb begin
        err = ERR_OK;
        if (year < c_year_min || year > c_year_max)
            err = ERR_YEAR;
        else if (day == 5'd0 || day > dim)
            err = ERR_DATE;
    end

endmodule

`default_nettype wire

// File: rtl/cal_dow_engine.sv
// ============================================================
// cal_dow_engine : date validation, day-of-week and day-offset engine
// Rev 1.0
// ============================================================
`default_nettype none

module cal_dow_engine
    import cal_pkg::*;
#(
    parameter int YEAR_W   = 16,
    parameter int YEAR_MIN = 1755,
    parameter int YEAR_MAX = 2033,
    parameter int ADD_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [YEAR_W-1:0] req_year,
    input  logic [3:0]        req_month,
    input  logic [4:0]        req_day,
    input  logic [ADD_W-1:0]  req_add,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [YEAR_W-1:0] rsp_year,
    output logic [3:0]        rsp_month,
    output logic [4:0]        rsp_day,
    output logic [2:0]        rsp_dow,
    output logic [1:0]        rsp_err
);

    localparam int                SUM_W      = YEAR_W + 2;
    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);

    state_t             r_state;
    logic               r_mode;
    logic [ADD_W-1:0]   r_cnt;
    logic [YEAR_W-1:0]  r_year;
    logic [3:0]         r_month;
    logic [4:0]         r_day;
    logic [2:0]         r_dow;
    logic [1:0]         r_err;
    logic               r_hold;

    logic [1:0]         w_chk_err;
    logic [4:0]         w_dim;
    logic [3:0]         w_midx;
    logic [SUM_W-1:0]   w_y;
    logic [SUM_W-1:0]   w_sum;
    logic [2:0]         w_dow_calc;
    logic               w_month_end;

    assign req_ready = (r_state == IDLE);

    cal_date_check #(
        .YEAR_W   (YEAR_W),
        .YEAR_MIN (YEAR_MIN),
        .YEAR_MAX (YEAR_MAX)
    ) u_check (
        .year  (r_year),
        .month (r_month),
        .day   (r_day),
        .err   (w_chk_err),
        .dim   (w_dim)
    );

    // January and February count as months of the previous year
    assign w_midx     = r_month - 4'd1;
    assign w_y        = SUM_W'(r_year) - ((r_month < 4'd3) ? SUM_W'(1) : SUM_W'(0));
    assign w_sum      = w_y + w_y / SUM_W'(4) - w_y / SUM_W'(100) + w_y / SUM_W'(400)
                      + SUM_W'(T_OFFSET[w_midx]) + SUM_W'(r_day);
    assign w_dow_calc = 3'(w_sum % SUM_W'(7));
    assign w_month_end = (r_day >= w_dim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= 1'b0;
            r_cnt     <= '0;
            r_year    <= '0;
            r_month   <= '0;
            r_day     <= '0;
            r_dow     <= DOW_SUN;
            r_err     <= ERR_OK;
            r_hold    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_year  <= '0;
            rsp_month <= '0;
            rsp_day   <= '0;
            rsp_dow   <= '0;
            rsp_err   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_mode  <= req_mode;
                        r_year  <= req_year;
                        r_month <= req_month;
                        r_day   <= req_day;
                        r_cnt   <= req_add;
                        r_dow   <= DOW_SUN;
                        r_err   <= ERR_OK;
                        r_hold  <= 1'b0;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_chk_err != ERR_OK) begin
                        // Error path skips DOW; hold one cycle to keep latency uniform
                        r_err   <= w_chk_err;
                        r_dow   <= DOW_SUN;
                        r_hold  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= DOW;
                    end
                end
                DOW: begin
                    r_dow <= w_dow_calc;
                    if (!r_mode || r_cnt == '0)
                        r_state <= DONE;
                    else
                        r_state <= STEP;
                end
                STEP: begin
                    if (w_month_end && r_month == 4'd12 && r_year == c_year_max) begin
                        r_err   <= ERR_OVF;
                        r_state <= DONE;
                    end else begin
                        if (!w_month_end) begin
                            r_day <= r_day + 5'd1;
                        end else if (r_month != 4'd12) begin
                            r_month <= r_month + 4'd1;
                            r_day   <= 5'd1;
                        end else begin
                            r_year  <= r_year + YEAR_W'(1);
                            r_month <= 4'd1;
                            r_day   <= 5'd1;
                        end
                        r_dow <= (r_dow == DOW_SAT) ? DOW_SUN : r_dow + 3'd1;
                        r_cnt <= r_cnt - ADD_W'(1);
                        if (r_cnt == ADD_W'(1))
                            r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!rsp_valid) begin
                        if (r_hold) begin
                            r_hold <= 1'b0;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_year  <= r_year;
                            rsp_month <= r_month;
                            rsp_day   <= r_day;
                            rsp_dow   <= r_dow;
                            rsp_err   <= r_err;
                        end
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cal_dow_engine.sv
// ============================================================
// tb_cal_dow_engine : directed table-driven bench for cal_dow_engine
// Rev 1.0
// ============================================================
`default_nettype none

module tb_cal_dow_engine;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [15:0] req_year;
    logic [3:0]  req_month;
    logic [4:0]  req_day;
    logic [15:0] req_add;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_year;
    logic [3:0]  rsp_month;
    logic [4:0]  rsp_day;
    logic [2:0]  rsp_dow;
    logic [1:0]  rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        mode;
        logic [15:0] year;
        logic [3:0]  month;
        logic [4:0]  day;
        logic [15:0] add;
        logic [15:0] e_year;
        logic [3:0]  e_month;
        logic [4:0]  e_day;
        logic [2:0]  e_dow;
        logic [1:0]  e_err;
        int          e_lat;   // 0 = latency not checked
    } vec_t;

    vec_t vecs[$];

    cal_dow_engine #(
        .YEAR_W   (16),
        .YEAR_MIN (1755),
        .YEAR_MAX (2033),
        .ADD_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_year  (req_year),
        .req_month (req_month),
        .req_day   (req_day),
        .req_add   (req_add),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_year  (rsp_year),
        .rsp_month (rsp_month),
        .rsp_day   (rsp_day),
        .rsp_dow   (rsp_dow),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one request and return after the accepting edge
    task automatic issue(input logic mode, input logic [15:0] y, input logic [3:0] m,
                         input logic [4:0] d, input logic [15:0] add);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!req_ready) check("req_ready timeout", 32'(req_ready), 32'd1);
        req_mode  = mode;
        req_year  = y;
        req_month = m;
        req_day   = d;
        req_add   = add;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 500) begin
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_valid timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic add_vec(input logic mode, input int y, input int m, input int d, input int add,
                           input int ey, input int em, input int ed, input int edow,
                           input int eerr, input int elat);
        vec_t v;
        v.mode = mode;       v.year = 16'(y);     v.month = 4'(m);   v.day = 5'(d);
        v.add = 16'(add);    v.e_year = 16'(ey);  v.e_month = 4'(em); v.e_day = 5'(ed);
        v.e_dow = 3'(edow);  v.e_err = 2'(eerr);  v.e_lat = elat;
        vecs.push_back(v);
    endtask

    initial begin
        int lat;
        bit seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        req_year  = '0;
        req_month = '0;
        req_day   = '0;
        req_add   = '0;
        rsp_ready = 1'b0;

        //       mode y     m   d   add  ey    em  ed  dow err lat
        add_vec(0, 2014, 10, 17, 0,   2014, 10, 17, 5, 0, 3);
        add_vec(0, 2000,  2, 29, 0,   2000,  2, 29, 2, 0, 3);
        add_vec(0, 1900,  2, 29, 0,   1900,  2, 29, 0, 2, 3);
        add_vec(0, 1754,  1,  1, 0,   1754,  1,  1, 0, 1, 3);
        add_vec(0, 2020, 13,  1, 0,   2020, 13,  1, 0, 2, 3);
        add_vec(0, 2034,  1,  1, 0,   2034,  1,  1, 0, 1, 3);
        add_vec(0, 2021,  4, 31, 0,   2021,  4, 31, 0, 2, 3);
        add_vec(0, 2021,  4,  0, 0,   2021,  4,  0, 0, 2, 3);
        add_vec(0, 1755,  1,  1, 0,   1755,  1,  1, 3, 0, 3);
        add_vec(0, 2033, 12, 31, 0,   2033, 12, 31, 6, 0, 3);
        add_vec(1, 2014, 12, 31, 1,   2015,  1,  1, 4, 0, 4);
        add_vec(1, 2016,  2, 28, 2,   2016,  3,  1, 2, 0, 5);
        add_vec(1, 2033, 12, 30, 5,   2033, 12, 31, 6, 3, 0);
        add_vec(1, 2024,  3, 10, 0,   2024,  3, 10, 0, 0, 3);
        add_vec(1, 2023, 12, 25, 10,  2024,  1,  4, 4, 0, 13);
        add_vec(1, 2000,  2, 28, 1,   2000,  2, 29, 2, 0, 4);
        add_vec(1, 1900,  2, 28, 1,   1900,  3,  1, 4, 0, 4);
        add_vec(1, 2021,  2, 29, 5,   2021,  2, 29, 0, 2, 3);

        #12;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_year",  32'(rsp_year),  32'd0);
        check("reset rsp_dow",   32'(rsp_dow),   32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].mode, vecs[i].year, vecs[i].month, vecs[i].day, vecs[i].add);
            wait_rsp(lat);
            if (vecs[i].e_lat != 0)
                check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].e_lat));
            check($sformatf("v%0d year", i),  32'(rsp_year),  32'(vecs[i].e_year));
            check($sformatf("v%0d month", i), 32'(rsp_month), 32'(vecs[i].e_month));
            check($sformatf("v%0d day", i),   32'(rsp_day),   32'(vecs[i].e_day));
            check($sformatf("v%0d dow", i),   32'(rsp_dow),   32'(vecs[i].e_dow));
            check($sformatf("v%0d err", i),   32'(rsp_err),   32'(vecs[i].e_err));
            release_rsp();
            check($sformatf("v%0d idle after handshake", i), 32'(req_ready), 32'd1);
            check($sformatf("v%0d valid dropped", i), 32'(rsp_valid), 32'd0);
        end

        // Backpressure, output hold, and no accept in the handshake cycle
        issue(1'b0, 16'd2014, 4'd10, 5'd17, 16'd0);
        wait_rsp(lat);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp req_ready", 32'(req_ready), 32'd0);
            check("bp rsp_dow",   32'(rsp_dow),   32'd5);
            check("bp rsp_day",   32'(rsp_day),   32'd17);
        end
        req_mode  = 1'b0;
        req_year  = 16'd2000;
        req_month = 4'd2;
        req_day   = 5'd29;
        req_add   = 16'd0;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp no bypass accept", 32'(req_ready), 32'd1);
        check("bp idle holds dow",   32'(rsp_dow),   32'd5);
        check("bp idle holds year",  32'(rsp_year),  32'd2014);
        tick();
        req_valid = 1'b0;
        check("bp next accept", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        check("bp second latency", 32'(lat), 32'd3);
        check("bp second dow",     32'(rsp_dow), 32'd2);
        release_rsp();

        // Reset in the middle of a long STEP sequence
        issue(1'b1, 16'd2020, 4'd1, 5'd1, 16'd100);
        for (int c = 1; c < 20; c++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset req_ready", 32'(req_ready), 32'd1);
        check("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset rsp_err",   32'(rsp_err),   32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("midreset no response", 32'(seen), 32'd0);
        check("midreset still idle",  32'(req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
